// File: rtl/mult_sched.sv
// Two-requester scheduler for one shared multiplier: round-robin grant, operand
// capture, response hand-off. Optional BUSY timeout/abort under MULT_SCHED_TIMEOUT_EN.
module mult_sched #(
  parameter int unsigned TIMEOUT_CYCLES = 48
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  output logic        req_ack0,
  output logic        req_ack1,
  output logic [31:0] mult_a,
  output logic [31:0] mult_b,
  output logic        mult_start,
  output logic        mult_abort,
  input  logic        mult_done,
  input  logic [31:0] mult_out,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  input  logic        rsp_ready
);

  localparam int unsigned DW = 32;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] BUSY = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("mult_sched: TIMEOUT_CYCLES must be at least 1");
  end

  logic [1:0]    state_q, state_d;
  logic          ptr_q, ptr_d;
  logic          gnt_q, gnt_d;
  logic          gnt_c;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic          start_q, start_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic          valid_q, valid_d;
  logic          id_q, id_d;
  logic [DW-1:0] data_q, data_d;

`ifdef MULT_SCHED_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          abort_q, abort_d;
  logic          err_q, err_d;
`endif

  // Next-state and registered-output computation
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    gnt_c   = 1'b0;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    start_d = 1'b0;
    a_d     = a_q;
    b_d     = b_q;
    valid_d = valid_q;
    id_d    = id_q;
    data_d  = data_q;
`ifdef MULT_SCHED_TIMEOUT_EN
    cnt_d   = cnt_q;
    abort_d = 1'b0;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // Pointer only matters on contention; a lone requester always wins
          gnt_c   = (req0 && req1) ? ptr_q : req1;
          gnt_d   = gnt_c;
          ack0_d  = ~gnt_c;
          ack1_d  = gnt_c;
          start_d = 1'b1;
          a_d     = gnt_c ? a1 : a0;
          b_d     = gnt_c ? b1 : b0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        state_d = BUSY;
`ifdef MULT_SCHED_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      BUSY: begin
        if (mult_done) begin
          valid_d = 1'b1;
          id_d    = gnt_q;
          data_d  = mult_out;
          a_d     = '0;
          b_d     = '0;
          state_d = RESP;
        end
`ifdef MULT_SCHED_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          abort_d = 1'b1;
          err_d   = 1'b1;
          valid_d = 1'b1;
          id_d    = gnt_q;
          data_d  = '0;
          a_d     = '0;
          b_d     = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      RESP: begin
        if (rsp_ready) begin
          valid_d = 1'b0;
          id_d    = 1'b0;
          data_d  = '0;
`ifdef MULT_SCHED_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          ptr_d   = ~gnt_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      gnt_q   <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      start_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
      id_q    <= 1'b0;
      data_q  <= '0;
`ifdef MULT_SCHED_TIMEOUT_EN
      cnt_q   <= '0;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      start_q <= start_d;
      a_q     <= a_d;
      b_q     <= b_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      data_q  <= data_d;
`ifdef MULT_SCHED_TIMEOUT_EN
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
      err_q   <= err_d;
`endif
    end
  end

  assign req_ack0   = ack0_q;
  assign req_ack1   = ack1_q;
  assign mult_start = start_q;
  assign mult_a     = a_q;
  assign mult_b     = b_q;
  assign rsp_valid  = valid_q;
  assign rsp_id     = id_q;
  assign rsp_data   = data_q;

`ifdef MULT_SCHED_TIMEOUT_EN
  assign mult_abort = abort_q;
  assign rsp_err    = err_q;
`else
  assign mult_abort = 1'b0;
  assign rsp_err    = 1'b0;
`endif

endmodule

// File: doc/mult_sched.md
MULT_SCHED -- requirements
Module: mult_sched

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 48: BUSY-state cycle limit before abort (used only with MULT_SCHED_TIMEOUT_EN).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports req0, req1  input  1 each  requester operation requests, level.
REQ-005 SHALL have ports a0, b0, a1, b1  input  32 each  requester operands.
REQ-006 SHALL have ports req_ack0, req_ack1  output  1 each  one-cycle grant/operand-capture pulses.
REQ-007 SHALL have ports mult_a, mult_b  output  32 each  operands to the shared multiplier.
REQ-008 SHALL have port mult_start  output  1  doMult pulse to the multiplier.
REQ-009 SHALL have port mult_abort  output  1  one-cycle abort/reset pulse to the multiplier.
REQ-010 SHALL have ports mult_done  input  1 and mult_out  input  32  multiplier completion flag and result.
REQ-011 SHALL have ports rsp_valid  output  1, rsp_id  output  1, rsp_data  output  32, rsp_err  output  1  response channel.
REQ-012 SHALL have port rsp_ready  input  1  response accept.

Function
REQ-013 SHALL implement states IDLE, LOAD, BUSY, RESP; at most one operation in flight.
REQ-014 IDLE SHALL sample req0/req1 each edge; if any is high, latch the winner's operands and id, then go to LOAD.
REQ-015 If both requests are high, SHALL grant the requester selected by a 1-bit round-robin pointer; the pointer SHALL point to the other requester after each completed response.
REQ-016 LOAD SHALL last exactly one cycle, with req_ack of the granted id and mult_start both high; next state BUSY.
REQ-017 mult_a/mult_b SHALL hold the latched operands from LOAD through BUSY and SHALL be 0 in IDLE.
REQ-018 BUSY SHALL wait for mult_done; on the edge mult_done is sampled high, SHALL capture mult_out into rsp_data and go to RESP.
REQ-019 RESP SHALL hold rsp_valid high with stable rsp_id/rsp_data/rsp_err until rsp_ready is sampled high, then go to IDLE.
REQ-020 Request-to-ack latency SHALL be 1 cycle; done-to-rsp_valid latency SHALL be 1 cycle.
REQ-021 mult_done SHALL be ignored in IDLE, LOAD and RESP.
REQ-022 Requests arriving in LOAD/BUSY/RESP SHALL wait, with no ack, until IDLE; requesters hold req until ack.
REQ-023 rsp_ready held low indefinitely SHALL keep RESP indefinitely, with no new grant.
REQ-024 A request present on the edge a response is accepted SHALL be sampled in the following IDLE cycle, not that edge.

Reset
REQ-025 Asserting reset, at any time including mid-operation, SHALL immediately force state IDLE, pointer 0, and all outputs 0.
REQ-026 After reset deassertion, the first sampled request SHALL see the full latencies of REQ-020; the aborted operation SHALL produce no response.

Configuration
REQ-027 With MULT_SCHED_TIMEOUT_EN defined, a BUSY cycle counter SHALL be present; when TIMEOUT_CYCLES cycles pass in BUSY without mult_done, SHALL pulse mult_abort for one cycle and enter RESP with rsp_err=1, rsp_data=0.
REQ-028 With MULT_SCHED_TIMEOUT_EN undefined, SHALL have no counter, mult_abort and rsp_err tied to 0, and BUSY waits without limit.

Verification
REQ-029 After reset, req0 with a0=3, b0=5; multiplier stub sets done 33 cycles after start -> ack0 1 cycle later, rsp_valid with id 0, data 15, err 0.
REQ-030 req0 and req1 both high in the first cycle after reset (a0=2,b0=7; a1=4,b1=9) -> id0 served first with data 14, then id1 with data 36; no overlap.
REQ-031 req0 held continuously with req1 also high -> grants alternate 0,1,0,1 over four operations.
REQ-032 rsp_ready low for 10 cycles in RESP -> rsp_valid/id/data stable and no ack for a pending req1; accept -> next IDLE grants req1.
REQ-033 reset asserted 10 cycles into BUSY -> all outputs 0 that cycle; no response emitted; a new req0 then completes normally.
REQ-034 With MULT_SCHED_TIMEOUT_EN and a stub that never sets done -> mult_abort pulses after 48 BUSY cycles; response has err 1, data 0.
